// File: rtl/p2_matrix_multiply_if.sv
// Board-side signal bundle for p2_matrix_multiply: display select, 7-segment digits and status.
interface p2_matrix_multiply_if;
    logic        SW0;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic [6:0]  HEX4;
    logic [6:0]  HEX5;
    logic [31:0] result;
    logic        done;

    modport master (
        output SW0,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, result, done
    );

    modport slave (
        input  SW0,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, result, done
    );
endinterface

// File: rtl/p2_matrix_multiply.sv
// C = A x B over constant N x N ROMs, one MAC per clock; reports the sum of all C elements,
// a sticky done flag and a six-digit hex display of either the sum or the cycle count.
module p2_matrix_multiply #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                CLOCK_50,
    input  logic                KEY0,
    p2_matrix_multiply_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IMAX = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   i;
    logic [IW-1:0]   j;
    logic [IW-1:0]   k;
    logic [31:0]     result;
    logic [23:0]     cnt;
    logic            done;
    logic            mac_en;
    logic            last_mac;
    logic [DW-1:0]   a_val;
    logic [DW-1:0]   b_val;
    logic [2*DW-1:0] prod;
    logic [31:0]     disp;

    // A[r][c] = N*r + c + 1
    function automatic logic [DW-1:0] rom_a(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return DW'(N * int'(r) + int'(c) + 1);
    endfunction

    // B[r][c] = N*N - (N*r + c)
    function automatic logic [DW-1:0] rom_b(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return DW'(N * N - (N * int'(r) + int'(c)));
    endfunction

    // Active-low hex digit, bit0 = segment a .. bit6 = segment g
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign a_val = rom_a(i, k);
    assign b_val = rom_b(k, j);
    assign prod  = a_val * b_val;

    // State register; a low KEY0 at any edge restarts from IDLE
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: IDLE -> RUN on the first released edge, RUN -> DONE with the final MAC
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = RUN;
            RUN:     if (last_mac) next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Control outputs of the FSM
    always_comb begin
        mac_en   = (state == RUN);
        last_mac = mac_en && (i == IMAX) && (j == IMAX) && (k == IMAX);
    end

    // Datapath: accumulate, count, walk k (inner), j, i (outer); everything holds outside RUN
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            i      <= '0;
            j      <= '0;
            k      <= '0;
            result <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else if (mac_en) begin
            result <= result + 32'(prod);
            cnt    <= cnt + 24'd1;
            if (k == IMAX) begin
                k <= '0;
                if (j == IMAX) begin
                    j <= '0;
                    i <= (i == IMAX) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end else begin
                k <= k + 1'b1;
            end
            if (last_mac) done <= 1'b1;
        end
    end

    // Display source select; SW0 only steers the digits
    always_comb begin
        disp = bus.SW0 ? {8'h00, cnt} : result;
    end

    assign bus.HEX0   = seg7(disp[3:0]);
    assign bus.HEX1   = seg7(disp[7:4]);
    assign bus.HEX2   = seg7(disp[11:8]);
    assign bus.HEX3   = seg7(disp[15:12]);
    assign bus.HEX4   = seg7(disp[19:16]);
    assign bus.HEX5   = seg7(disp[23:20]);
    assign bus.result = result;
    assign bus.done   = done;
endmodule

// File: tb/tb_p2_matrix_multiply.sv
// Scoreboard bench for p2_matrix_multiply: stimulus queues expected result/done/display
// values tagged with the cycle they apply to; a negedge monitor pops and compares them.
module tb_p2_matrix_multiply;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    p2_matrix_multiply_if bus ();

    p2_matrix_multiply #(.N(4), .DW(8)) dut (
        .CLOCK_50 (clk),
        .KEY0     (rst_n),
        .bus      (bus)
    );

    typedef struct {
        string       name;
        int          at;
        logic [31:0] res;
        logic        dn;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc   = 0;
    int   nvec  = 0;
    int   nmiss = 0;
    int   r0;
    int   q0;
    int   s0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference segment table, active-low, bit0 = a
    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        logic [6:0] t [16];
        t[0]  = 7'b1000000; t[1]  = 7'b1111001; t[2]  = 7'b0100100; t[3]  = 7'b0110000;
        t[4]  = 7'b0011001; t[5]  = 7'b0010010; t[6]  = 7'b0000010; t[7]  = 7'b1111000;
        t[8]  = 7'b0000000; t[9]  = 7'b0010000; t[10] = 7'b0001000; t[11] = 7'b0000011;
        t[12] = 7'b1000110; t[13] = 7'b0100001; t[14] = 7'b0000110; t[15] = 7'b0001110;
        return t[h];
    endfunction

    function automatic logic [41:0] ref_hex(input logic [31:0] v);
        logic [41:0] r;
        r = '0;
        for (int n = 0; n < 6; n++) r[7*n +: 7] = ref_seg(v[4*n +: 4]);
        return r;
    endfunction

    task automatic push_exp(input string name, input int at, input logic [31:0] res,
                            input logic dn, input logic [31:0] v);
        exp_t x;
        x.name = name;
        x.at   = at;
        x.res  = res;
        x.dn   = dn;
        x.v    = v;
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            logic [41:0] hx;
            e = sb.pop_front();
            nvec++;
            hx = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
            if (e.at != cyc) begin
                nmiss++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.at);
            end else begin
                if (bus.result !== e.res) begin
                    nmiss++;
                    $display("FAIL %s result @%0d: got %0d (0x%08h), required %0d (0x%08h)",
                             e.name, cyc, bus.result, bus.result, e.res, e.res);
                end
                if (bus.done !== e.dn) begin
                    nmiss++;
                    $display("FAIL %s done @%0d: got %b, required %b", e.name, cyc, bus.done, e.dn);
                end
                if (hx !== ref_hex(e.v)) begin
                    nmiss++;
                    $display("FAIL %s hex @%0d: got %h, required %h (value 0x%06h)",
                             e.name, cyc, hx, ref_hex(e.v), e.v[23:0]);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        bus.SW0 = 1'b0;

        // Reset held for two edges
        tick(2);
        push_exp("reset_hold", cyc, 32'd0, 1'b0, 32'd0);

        // First run: IDLE edge, then 64 MACs
        r0    = cyc;
        rst_n = 1'b1;
        push_exp("enter_run",   r0 + 1,  32'd0,    1'b0, 32'd0);
        push_exp("mac1",        r0 + 2,  32'd16,   1'b0, 32'd16);
        push_exp("mac2",        r0 + 3,  32'd40,   1'b0, 32'd40);
        push_exp("mac3",        r0 + 4,  32'd64,   1'b0, 32'd64);
        push_exp("mac4_c00",    r0 + 5,  32'd80,   1'b0, 32'd80);
        push_exp("before_done", r0 + 64, 32'd4288, 1'b0, 32'd4288);
        push_exp("done_rise",   r0 + 65, 32'h10D0, 1'b1, 32'h10D0);
        tick(66);

        // Display select after completion
        bus.SW0 = 1'b1;
        push_exp("sw_cnt", cyc, 32'h10D0, 1'b1, 32'h40);
        tick(1);
        bus.SW0 = 1'b0;
        push_exp("sw_back", cyc, 32'h10D0, 1'b1, 32'h10D0);

        // DONE holds for 100 cycles
        for (int n = 1; n < 100; n++) push_exp("done_hold", cyc + n, 32'h10D0, 1'b1, 32'h10D0);
        tick(100);
        bus.SW0 = 1'b1;
        push_exp("hold_cnt", cyc, 32'h10D0, 1'b1, 32'h40);

        // Reset out of DONE, rerun, abort after 30 MACs
        tick(1);
        bus.SW0 = 1'b0;
        rst_n   = 1'b0;
        q0      = cyc;
        push_exp("restart_clear", q0 + 1, 32'd0, 1'b0, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(31);
        bus.SW0 = 1'b1;
        push_exp("mac30_cnt", cyc, 32'd1021, 1'b0, 32'd30);
        rst_n = 1'b0;
        tick(1);
        bus.SW0 = 1'b0;
        push_exp("abort_clear", cyc, 32'd0, 1'b0, 32'd0);

        // Full rerun after abort
        s0    = cyc;
        rst_n = 1'b1;
        push_exp("rerun_mac1",   s0 + 2,  32'd16,   1'b0, 32'd16);
        push_exp("rerun_before", s0 + 64, 32'd4288, 1'b0, 32'd4288);
        push_exp("rerun_done",   s0 + 65, 32'h10D0, 1'b1, 32'h10D0);
        tick(66);
        bus.SW0 = 1'b1;
        push_exp("rerun_cnt", cyc, 32'h10D0, 1'b1, 32'h40);
        tick(2);

        if (sb.size() != 0) begin
            nmiss++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
